// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit: iterates a fixed shift-by-2 stage plus an optional shift-by-1,
// returning the result in data_out with a one-cycle done pulse.
module shift_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [DATA_W-1:0]  data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  data_out
);

  typedef enum logic [1:0] {StIdle, StShift2, StShift1, StDone} state_e;

  localparam logic [SHAMT_W-1:0] CntOne = SHAMT_W'(1);
  localparam logic [SHAMT_W-1:0] CntTwo = SHAMT_W'(2);

  state_e              state_q;
  logic [DATA_W-1:0]   acc_q;
  logic [DATA_W-1:0]   data_out_q;
  logic [SHAMT_W-1:0]  cnt_q;
  logic [1:0]          op_q;

  logic [DATA_W-1:0]   acc_sh2;
  logic [DATA_W-1:0]   acc_sh1;
  logic [SHAMT_W-1:0]  cnt_m2;

  // Fill bits come from the captured operand, so SRA never sees live data_in.
  always_comb begin
    acc_sh2 = {acc_q[DATA_W-3:0], 2'b00};
    acc_sh1 = {acc_q[DATA_W-2:0], 1'b0};
    unique case (op_q)
      2'b01: begin
        acc_sh2 = {2'b00, acc_q[DATA_W-1:2]};
        acc_sh1 = {1'b0, acc_q[DATA_W-1:1]};
      end
      2'b10: begin
        acc_sh2 = {{2{acc_q[DATA_W-1]}}, acc_q[DATA_W-1:2]};
        acc_sh1 = {acc_q[DATA_W-1], acc_q[DATA_W-1:1]};
      end
      default: ;
    endcase
  end

  assign cnt_m2 = cnt_q - CntTwo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      cnt_q      <= '0;
      op_q       <= 2'b00;
      data_out_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            acc_q <= data_in;
            cnt_q <= shamt;
            op_q  <= op;
            if (shamt >= CntTwo) begin
              state_q <= StShift2;
            end else if (shamt == CntOne) begin
              state_q <= StShift1;
            end else begin
              data_out_q <= data_in;
              state_q    <= StDone;
            end
          end
        end
        StShift2: begin
          acc_q <= acc_sh2;
          cnt_q <= cnt_m2;
          if (cnt_m2 >= CntTwo) begin
            state_q <= StShift2;
          end else if (cnt_m2 == CntOne) begin
            state_q <= StShift1;
          end else begin
            data_out_q <= acc_sh2;
            state_q    <= StDone;
          end
        end
        StShift1: begin
          acc_q      <= acc_sh1;
          cnt_q      <= cnt_q - CntOne;
          data_out_q <= acc_sh1;
          state_q    <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);
  assign data_out = data_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: expected results queued at start, checked at done.
module tb_shift_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] data_out;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  shift_sequencer #(
    .DATA_W  (32),
    .SHAMT_W (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .data_in  (data_in),
    .shamt    (shamt),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] model(input logic [1:0] m_op, input logic [31:0] d,
                                        input logic [4:0] s);
    case (m_op)
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return d << s;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Launch one operation and follow it to done; optionally pulse start while busy.
  task automatic run(input string tag, input logic [1:0] r_op, input logic [31:0] d,
                     input logic [4:0] s, input bit interfere);
    logic [31:0] prev;
    logic [31:0] expv;
    int          lat_exp;
    bit          got;
    @(negedge clk);
    start   = 1'b1;
    op      = r_op;
    data_in = d;
    shamt   = s;
    exp_q.push_back(model(r_op, d, s));
    lat_exp = 1 + int'(s) / 2 + int'(s) % 2;
    prev    = data_out;
    got     = 1'b0;
    for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      data_in = $urandom;
      shamt   = 5'($urandom);
      op      = 2'($urandom);
      if (interfere && cyc == 3) begin
        start   = 1'b1;
        op      = 2'b10;
        data_in = 32'hDEADBEEF;
        shamt   = 5'd1;
      end
      if (done) begin
        got = 1'b1;
        check({tag, " latency"}, 32'(cyc), 32'(lat_exp));
        check({tag, " busy@done"}, 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          check({tag, " queue"}, 32'd0, 32'd1);
        end else begin
          expv = exp_q.pop_front();
          check({tag, " data_out"}, data_out, expv);
        end
        if (interfere) start = 1'b1;
      end else begin
        check({tag, " busy"}, 32'(busy), 32'd1);
        check({tag, " hold"}, data_out, prev);
      end
    end
    if (!got) check({tag, " timeout"}, 32'(done), 32'd1);
    @(negedge clk);
    start = 1'b0;
    check({tag, " idle busy"}, 32'(busy), 32'd0);
    check({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    op      = 2'b00;
    data_in = 32'h0;
    shamt   = 5'd0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset data_out", data_out, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run("sll1x2", 2'b00, 32'h00000001, 5'd2, 1'b0);
    run("sra31", 2'b10, 32'h80000000, 5'd31, 1'b0);
    run("srl5", 2'b01, 32'hF0F0F0F0, 5'd5, 1'b0);
    run("sll1", 2'b00, 32'h0000FFFF, 5'd1, 1'b0);
    run("sll0", 2'b00, 32'h00001234, 5'd0, 1'b0);
    run("op11", 2'b11, 32'h00000003, 5'd4, 1'b0);
    run("sra_busy", 2'b10, 32'h80000000, 5'd31, 1'b1);
    run("sra_pos", 2'b10, 32'h7654_3210, 5'd7, 1'b0);

    // Abort an SLL shamt=20 mid-SHIFT2 with an asynchronous reset.
    @(negedge clk);
    start   = 1'b1;
    op      = 2'b00;
    data_in = 32'h0000_0ABC;
    shamt   = 5'd20;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre-reset busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset data_out", data_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post-reset no done", 32'(done), 32'd0);
    end
    run("srl8", 2'b01, 32'h00000100, 5'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
